multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
// - Parametrised multicycle MIPS control unit: FSM with FETCH/DECODE/EXEC/MEM/WB states, one-hot phase output.
// - Path length varies per opcode (3-5 states). Memory accesses use a req/ack handshake with a bounded timeout.
// - Sits between the instruction register and the datapath muxes/write-enables of the multicycle CPU.
// PARAMETERS
// - OP_W     6   opcode width
// - TO_W     4   timeout counter width
// - TIMEOUT  15  max wait cycles for an ack; 0 = wait forever, no timeout
// - CNT_W    32  width of the performance counters (only with MCC_PERF_CNT_EN)
// PORTS
// - clk        in  1       rising-edge clock; the only clock
// - reset      in  1       synchronous, active-high
// - hold       in  1       freeze: FSM, counters and all outputs keep their value
// - op         in  OP_W    opcode from the IR; sampled in DECODE only
// - imem_ack   in  1       instruction fetch done
// - dmem_ack   in  1       data access done
// - phase      out 5       one-hot state {WB,MEM,EXEC,DECODE,FETCH}
// - imem_req   out 1       high throughout FETCH
// - ir_we/pc_we out 1     1-cycle pulse on the FETCH cycle where imem_ack=1
// - dmem_req   out 1       high throughout MEM
// - dmem_we    out 1       high with dmem_req for SW only
// - alu_src    out 2       00 imm, 01 reg, 10 compare; valid in EXEC, else 00
// - alu_fn_en  out 1       R-type uses funct field; valid in EXEC
// - branch_en  out 1       1-cycle pulse in EXEC for BNE
// - jump_en    out 1       1-cycle pulse in EXEC for J
// - reg_we     out 1       1-cycle pulse in WB
// - wb_sel     out 1       1 = memory data (LW), 0 = ALU result
// - illegal    out 1       1-cycle pulse in DECODE on an unknown opcode
// - bus_err    out 1       1-cycle pulse when a timeout fires
// - perf_instr/perf_stall out CNT_W   only with MCC_PERF_CNT_EN
// BEHAVIOUR
// - Reset: state=FETCH, phase=5'b00001, every other output 0, timeout counter 0. Reset overrides hold.
// - Per-opcode paths:
//   - R(000000), ADDI(001000): F-D-E-WB
//   - LW(100011): F-D-E-M-WB
//   - SW(101011): F-D-E-M
//   - BNE(000101), J(000010): F-D-E
// - An unknown opcode raises illegal in DECODE and returns to FETCH with no enables.
// - FETCH: stays until imem_ack. Moves to DECODE the cycle after the ack, with ir_we/pc_we pulsing in the ack cycle.
// - MEM: stays until dmem_ack. The ack cycle exits MEM: LW goes to WB, SW goes to FETCH.
// - Timeout: counter clears on state entry and increments each waiting cycle. When it equals TIMEOUT with no ack, bus_err pulses and the FSM goes to FETCH with no write-enables.
// - An ack and a timeout in the same cycle: the ack wins.
// - Decode outputs are registered by the state, not by op. op changes outside DECODE have no effect.
// - hold=1: all state frozen. A pulse in progress is held (reg_we stays high) until hold drops. An ack arriving under hold is ignored.
// - Reset mid-access: req drops the next cycle and the FSM restarts in FETCH.
// CONFIGURATION
// - MCC_PERF_CNT_EN defined:
//   - perf_instr increments on each return to FETCH from a completed instruction (not illegal, not bus_err).
//   - perf_stall increments each FETCH/MEM cycle without an ack.
//   - Both wrap at 2^CNT_W, are cleared by reset and are frozen by hold.
// - MCC_PERF_CNT_EN undefined: the counter ports and logic are absent. All other behaviour is identical.
// STRUCTURE
// - Package mcc_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BNE, OP_J, OP_ADDI), state enum/one-hot indices, alu_src codes.
// - Sub-module mcc_ack_timer: wait counter, clear-on-entry, expired flag. Instantiated once, shared by FETCH and MEM.
// TESTING
// - Reset then R-type with imem_ack in FETCH cycle 1: phase 01,02,04,10; reg_we=1 in WB, wb_sel=0; perf_instr=1.
// - LW with dmem_ack after 3 MEM cycles: dmem_req high 3 cycles, dmem_we=0, WB with wb_sel=1, perf_stall=2.
// - SW: dmem_we=1 with dmem_req, FSM returns to FETCH after MEM, reg_we never asserted.
// - BNE then J: branch_en and then jump_en each pulse once in EXEC with alu_src=10/00; 3 cycles per instruction.
// - op=6'b111111: illegal pulses in DECODE, next state FETCH, no enables.
// - TIMEOUT=3, imem_ack never arrives: bus_err pulses in the 4th FETCH cycle. Ack together with expiry -> no bus_err.
// - hold asserted in WB for 2 cycles: reg_we stays high 3 cycles total, phase unchanged.
// - Reset during MEM: dmem_req=0 next cycle, phase=00001.

Source files
------------

// File: rtl/mcc_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, one-hot states,
// decoded instruction classes and ALU operand-select codes.
package mcc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;

    // State encoding is the phase output itself.
    typedef enum logic [4:0] {
        ST_FETCH  = 5'b00001,
        ST_DECODE = 5'b00010,
        ST_EXEC   = 5'b00100,
        ST_MEM    = 5'b01000,
        ST_WB     = 5'b10000
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILL, CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BNE, CLS_J
    } op_cls_t;

    localparam logic [1:0] ALU_IMM = 2'b00;
    localparam logic [1:0] ALU_REG = 2'b01;
    localparam logic [1:0] ALU_CMP = 2'b10;

endpackage

// File: rtl/mcc_ack_timer.sv
// Ack wait counter shared by FETCH and MEM. Restarts from zero whenever the
// controller is not waiting or the wait ends; TIMEOUT=0 disables expiry.
module mcc_ack_timer #(
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam bit TO_EN = (TIMEOUT != 0);

    logic [TO_W-1:0] cnt_reg;
    logic [TO_W-1:0] cnt_next;

    assign expired = TO_EN && waiting && (cnt_reg == TO_W'(TIMEOUT));

    // Any exit from a wait (ack or expiry) zeroes the count, so the next
    // waiting state always starts fresh.
    always_comb begin
        cnt_next = '0;
        if (TO_EN && waiting && !ack && !expired)
            cnt_next = cnt_reg + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_reg <= '0;
        else if (!hold)
            cnt_reg <= cnt_next;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with req/ack memory
// handshakes and timeout. Define MCC_PERF_CNT_EN to add perf_instr/perf_stall.
module multicycle_ctrl
    import mcc_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
`ifdef MCC_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic [OP_W-1:0] op,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    output logic [4:0]      phase,
    output logic            imem_req,
    output logic            ir_we,
    output logic            pc_we,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [1:0]      alu_src,
    output logic            alu_fn_en,
    output logic            branch_en,
    output logic            jump_en,
    output logic            reg_we,
    output logic            wb_sel,
    output logic            illegal,
    output logic            bus_err
`ifdef MCC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_instr,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    state_t  state_reg, state_next;
    op_cls_t cls_reg, cls_next, cls_dec;
    logic    in_fetch, in_decode, in_exec, in_mem, in_wb;
    logic    wait_ack, expired;

    assign in_fetch  = state_reg[PH_FETCH];
    assign in_decode = state_reg[PH_DECODE];
    assign in_exec   = state_reg[PH_EXEC];
    assign in_mem    = state_reg[PH_MEM];
    assign in_wb     = state_reg[PH_WB];
    assign wait_ack  = (in_fetch && imem_ack) || (in_mem && dmem_ack);

    mcc_ack_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .waiting (in_fetch || in_mem),
        .ack     (wait_ack),
        .expired (expired)
    );

    always_comb begin
        cls_dec = CLS_ILL;
        case (op)
            OP_W'(OP_RTYPE): cls_dec = CLS_R;
            OP_W'(OP_ADDI):  cls_dec = CLS_ADDI;
            OP_W'(OP_LW):    cls_dec = CLS_LW;
            OP_W'(OP_SW):    cls_dec = CLS_SW;
            OP_W'(OP_BNE):   cls_dec = CLS_BNE;
            OP_W'(OP_J):     cls_dec = CLS_J;
            default:         cls_dec = CLS_ILL;
        endcase
    end

    // Acks take priority over expiry; an expiry in FETCH simply restarts FETCH.
    always_comb begin
        state_next = state_reg;
        cls_next   = cls_reg;
        unique case (state_reg)
            ST_FETCH: begin
                if (imem_ack)
                    state_next = ST_DECODE;
            end
            ST_DECODE: begin
                cls_next   = cls_dec;
                state_next = (cls_dec == CLS_ILL) ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
                unique case (cls_reg)
                    CLS_R, CLS_ADDI: state_next = ST_WB;
                    CLS_LW, CLS_SW:  state_next = ST_MEM;
                    default:         state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack)
                    state_next = (cls_reg == CLS_LW) ? ST_WB : ST_FETCH;
                else if (expired)
                    state_next = ST_FETCH;
            end
            ST_WB:   state_next = ST_FETCH;
            default: state_next = ST_FETCH;
        endcase
        if (hold) begin
            state_next = state_reg;
            cls_next   = cls_reg;
        end
    end

    always_comb begin
        phase     = reset ? ST_FETCH : state_reg;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src   = ALU_IMM;
        alu_fn_en = 1'b0;
        branch_en = 1'b0;
        jump_en   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        illegal   = 1'b0;
        bus_err   = 1'b0;
        if (!reset) begin
            imem_req = in_fetch;
            ir_we    = in_fetch && imem_ack && !hold;
            pc_we    = in_fetch && imem_ack && !hold;
            dmem_req = in_mem;
            dmem_we  = in_mem && (cls_reg == CLS_SW);
            if (in_exec) begin
                unique case (cls_reg)
                    CLS_R: begin
                        alu_src   = ALU_REG;
                        alu_fn_en = 1'b1;
                    end
                    CLS_BNE: begin
                        alu_src   = ALU_CMP;
                        branch_en = 1'b1;
                    end
                    CLS_J:   jump_en = 1'b1;
                    default: alu_src = ALU_IMM;
                endcase
            end
            reg_we  = in_wb;
            wb_sel  = in_wb && (cls_reg == CLS_LW);
            illegal = in_decode && (cls_dec == CLS_ILL);
            bus_err = expired && !wait_ack && !hold;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            cls_reg   <= CLS_ILL;
        end else begin
            state_reg <= state_next;
            cls_reg   <= cls_next;
        end
    end

`ifdef MCC_PERF_CNT_EN
    logic instr_done, stall_cycle;
    logic [CNT_W-1:0] perf_instr_reg, perf_stall_reg;

    always_comb begin
        instr_done  = !hold && (in_wb
                    || (in_exec && (cls_reg == CLS_BNE || cls_reg == CLS_J))
                    || (in_mem && dmem_ack && cls_reg == CLS_SW));
        stall_cycle = !hold && ((in_fetch && !imem_ack) || (in_mem && !dmem_ack));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (instr_done)
                perf_instr_reg <= perf_instr_reg + CNT_W'(1);
            if (stall_cycle)
                perf_stall_reg <= perf_stall_reg + CNT_W'(1);
        end
    end

    assign perf_instr = perf_instr_reg;
    assign perf_stall = perf_stall_reg;
`endif

endmodule
